// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM states, grant IDs and bus widths.
// Optional stall counters are enabled by defining ARB_STALL_CNT_EN.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned BSEL_W     = 4;

  localparam logic [BSEL_W-1:0] BSEL_ALL = '1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_D = 2'd1,
    ARB_GNT_I = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_stall_counter.sv
// Saturating enable-driven cycle counter, used for stall statistics.
// Present only when ARB_STALL_CNT_EN is defined.
`ifdef ARB_STALL_CNT_EN
module mem_port_arbiter_stall_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM-stage loads/stores onto one single-port memory.
// Defining ARB_STALL_CNT_EN adds per-requester saturating stall-cycle counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic              if_flush,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BSEL_W-1:0] d_byte_slct,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
`ifdef ARB_STALL_CNT_EN
  output logic [31:0]       if_stall_cnt,
  output logic [31:0]       d_stall_cnt,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BSEL_W-1:0] mem_byte_slct,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t        state, state_nxt;
  grant_t            last_grant, last_grant_nxt;
  logic              flushed, flushed_nxt;
  logic              mem_req_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic [BSEL_W-1:0] mem_byte_slct_nxt;
  logic [DATA_W-1:0] if_rdata_nxt, d_rdata_nxt;
  logic              if_done_nxt, d_done_nxt;
  logic              d_cand, i_cand;

  assign d_cand   = d_re | d_we;
  assign i_cand   = if_req & ~if_flush;
  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_cand & ~d_done;

  // Next-state and registered-output logic
  always_comb begin
    state_nxt         = state;
    last_grant_nxt    = last_grant;
    flushed_nxt       = flushed;
    mem_req_nxt       = 1'b0;
    mem_we_nxt        = mem_we;
    mem_addr_nxt      = mem_addr;
    mem_wdata_nxt     = mem_wdata;
    mem_byte_slct_nxt = mem_byte_slct;
    if_rdata_nxt      = if_rdata;
    d_rdata_nxt       = d_rdata;
    if_done_nxt       = 1'b0;
    d_done_nxt        = 1'b0;

    unique case (state)
      ARB_IDLE: begin
        flushed_nxt = 1'b0;
        // Data wins unless it was granted last time and a fetch is waiting
        if (d_cand && !((last_grant == GNT_D) && i_cand)) begin
          state_nxt         = ARB_GNT_D;
          last_grant_nxt    = GNT_D;
          mem_req_nxt       = 1'b1;
          mem_we_nxt        = d_we;
          mem_addr_nxt      = d_addr;
          mem_wdata_nxt     = d_we ? d_wdata : '0;
          mem_byte_slct_nxt = d_we ? d_byte_slct : BSEL_ALL;
        end else if (i_cand) begin
          state_nxt         = ARB_GNT_I;
          last_grant_nxt    = GNT_IF;
          mem_req_nxt       = 1'b1;
          mem_we_nxt        = 1'b0;
          mem_addr_nxt      = if_addr;
          mem_wdata_nxt     = '0;
          mem_byte_slct_nxt = BSEL_ALL;
        end
      end
      ARB_GNT_D: begin
        if (mem_ready) begin
          state_nxt   = ARB_RESP;
          d_rdata_nxt = mem_rdata;
          d_done_nxt  = 1'b1;
        end else begin
          mem_req_nxt = 1'b1;
        end
      end
      ARB_GNT_I: begin
        // A flush seen at any point of the access suppresses its done pulse
        flushed_nxt = flushed | if_flush;
        if (mem_ready) begin
          state_nxt    = ARB_RESP;
          if_rdata_nxt = mem_rdata;
          if_done_nxt  = ~(flushed | if_flush);
        end else begin
          mem_req_nxt = 1'b1;
        end
      end
      ARB_RESP: begin
        state_nxt = ARB_IDLE;
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ARB_IDLE;
      last_grant    <= GNT_IF;
      flushed       <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_byte_slct <= '0;
      if_rdata      <= '0;
      d_rdata       <= '0;
      if_done       <= 1'b0;
      d_done        <= 1'b0;
    end else begin
      state         <= state_nxt;
      last_grant    <= last_grant_nxt;
      flushed       <= flushed_nxt;
      mem_req       <= mem_req_nxt;
      mem_we        <= mem_we_nxt;
      mem_addr      <= mem_addr_nxt;
      mem_wdata     <= mem_wdata_nxt;
      mem_byte_slct <= mem_byte_slct_nxt;
      if_rdata      <= if_rdata_nxt;
      d_rdata       <= d_rdata_nxt;
      if_done       <= if_done_nxt;
      d_done        <= d_done_nxt;
    end
  end

`ifdef ARB_STALL_CNT_EN
  mem_port_arbiter_stall_counter #(.WIDTH(32)) u_if_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (if_stall),
    .count (if_stall_cnt)
  );

  mem_port_arbiter_stall_counter #(.WIDTH(32)) u_d_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (d_stall),
    .count (d_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush;
  logic [31:0] if_addr, if_rdata;
  logic        if_done, if_stall;
  logic        d_re, d_we;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_byte_slct;
  logic        d_done, d_stall;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byte_slct;
`ifdef ARB_STALL_CNT_EN
  logic [31:0] if_stall_cnt, d_stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = free, 1 = memory access open, 2 = completion cycle
  int          m_phase;
  bit          m_own_d, m_last_d;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic        e_we;
  logic [3:0]  e_bsel;
  bit          i_was_done, d_was_done, acc_open;
  int          wait_left;
  int          kind;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_flush(if_flush), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_slct(d_byte_slct), .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
`ifdef ARB_STALL_CNT_EN
    .if_stall_cnt(if_stall_cnt), .d_stall_cnt(d_stall_cnt),
`endif
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte_slct(mem_byte_slct), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 0; if_flush = 0; if_addr = '0;
    d_re = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_byte_slct = '0;
    mem_rdata = '0; mem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk32("rst_mem_bsel", 32'(mem_byte_slct), 32'h0);
    chk1("rst_if_done", if_done, 1'b0);
    chk1("rst_d_done", d_done, 1'b0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_d_rdata", d_rdata, 32'h0);
    chk1("rst_if_stall", if_stall, 1'b0);
    chk1("rst_d_stall", d_stall, 1'b0);
`ifdef ARB_STALL_CNT_EN
    chk32("rst_if_cnt", if_stall_cnt, 32'h0);
    chk32("rst_d_cnt", d_stall_cnt, 32'h0);
`endif
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // 1: IF-only fetch with zero wait states
    cyc(); if_req = 1; if_addr = 32'h100;
    #1; chk1("t1_stall_c0", if_stall, 1'b1); chk1("t1_mreq_c0", mem_req, 1'b0);
    cyc(); chk1("t1_mreq_c1", mem_req, 1'b1); chk32("t1_maddr", mem_addr, 32'h100);
    chk1("t1_mwe", mem_we, 1'b0); chk32("t1_bsel", 32'(mem_byte_slct), 32'hF);
    mem_ready = 1; mem_rdata = 32'h2402_0005;
    #1; chk1("t1_stall_c1", if_stall, 1'b1);
    cyc(); mem_ready = 0;
    chk1("t1_done", if_done, 1'b1); chk32("t1_rdata", if_rdata, 32'h2402_0005);
    chk1("t1_mreq_c2", mem_req, 1'b0);
    #1; chk1("t1_stall_c2", if_stall, 1'b0);
    if_req = 0;
    cyc(); chk1("t1_done_c3", if_done, 1'b0);

    // 2: simultaneous requests; D first, then IF despite D re-requesting
    cyc(); if_req = 1; if_addr = 32'h104; d_re = 1; d_addr = 32'h200;
    cyc(); chk1("t2_mreq_d", mem_req, 1'b1); chk32("t2_addr_d", mem_addr, 32'h200);
    chk1("t2_we_d", mem_we, 1'b0);
    mem_ready = 1; mem_rdata = 32'h1111_2222;
    cyc(); mem_ready = 0;
    chk1("t2_d_done", d_done, 1'b1); chk32("t2_d_rdata", d_rdata, 32'h1111_2222);
    chk1("t2_if_done0", if_done, 1'b0);
    d_addr = 32'h204;
    #1; chk1("t2_d_stall_done", d_stall, 1'b0);
    cyc(); chk1("t2_d_done_off", d_done, 1'b0); chk1("t2_mreq_idle", mem_req, 1'b0);
    cyc(); chk1("t2_mreq_i", mem_req, 1'b1); chk32("t2_addr_i", mem_addr, 32'h104);
    mem_ready = 1; mem_rdata = 32'h3333_4444;
    cyc(); mem_ready = 0;
    chk1("t2_if_done", if_done, 1'b1); chk32("t2_if_rdata", if_rdata, 32'h3333_4444);
    if_req = 0;
    #1; chk1("t2_d_stall_wait", d_stall, 1'b1);
    cyc();
    cyc(); chk32("t2_addr_d2", mem_addr, 32'h204);
    mem_ready = 1; mem_rdata = 32'h5555_6666;
    cyc(); mem_ready = 0; chk1("t2_d_done2", d_done, 1'b1);
    d_re = 0;
    cyc();

    // 3: store with three wait states; input changes mid-access are ignored
    cyc(); d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_byte_slct = 4'b0011;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk1("t3_mreq", mem_req, 1'b1); chk1("t3_mwe", mem_we, 1'b1);
      chk32("t3_maddr", mem_addr, 32'h40); chk32("t3_mwdata", mem_wdata, 32'hDEAD_BEEF);
      chk32("t3_bsel", 32'(mem_byte_slct), 32'h3); chk1("t3_no_done", d_done, 1'b0);
      if (k == 2) begin d_wdata = 32'h0BAD_F00D; d_addr = 32'h44; end
      mem_ready = (k == 4);
    end
    cyc(); mem_ready = 0;
    chk1("t3_done", d_done, 1'b1); chk1("t3_mreq_off", mem_req, 1'b0);
    d_we = 0;
    cyc();

    // 4: flush during GNT_I, then flush in IDLE
    cyc(); if_req = 1; if_addr = 32'h200;
    cyc(); chk1("t4_mreq", mem_req, 1'b1); chk32("t4_addr", mem_addr, 32'h200);
    if_flush = 1;
    cyc(); if_flush = 0; chk1("t4_runs", mem_req, 1'b1); chk32("t4_addr2", mem_addr, 32'h200);
    mem_ready = 1; mem_rdata = 32'h7777_7777;
    cyc(); mem_ready = 0;
    chk1("t4_no_done", if_done, 1'b0); chk1("t4_mreq_off", mem_req, 1'b0);
    if_addr = 32'h300;
    #1; chk1("t4_stall", if_stall, 1'b1);
    cyc(); chk1("t4_no_done2", if_done, 1'b0);
    cyc(); chk1("t4_refetch", mem_req, 1'b1); chk32("t4_addr3", mem_addr, 32'h300);
    mem_ready = 1; mem_rdata = 32'h8888_8888;
    cyc(); mem_ready = 0;
    chk1("t4_done", if_done, 1'b1); chk32("t4_rdata", if_rdata, 32'h8888_8888);
    cyc(); if_addr = 32'h400; if_flush = 1;
    cyc(); chk1("t4_idle_flush", mem_req, 1'b0); if_flush = 0;
    cyc(); chk1("t4_after_flush", mem_req, 1'b1); chk32("t4_addr4", mem_addr, 32'h400);
    mem_ready = 1; mem_rdata = 32'h9999_9999;
    cyc(); mem_ready = 0; chk1("t4_done2", if_done, 1'b1);
    if_req = 0;
    cyc();

    // 5: reset during GNT_D aborts the access
    cyc(); d_re = 1; d_addr = 32'h80;
    cyc(); chk1("t5_mreq", mem_req, 1'b1);
    rst = 1;
    #1; chk1("t5_async_drop", mem_req, 1'b0); chk1("t5_no_done", d_done, 1'b0);
    cyc(); chk1("t5_in_rst", mem_req, 1'b0);
    cyc(); rst = 0;
    #1; chk1("t5_idle", mem_req, 1'b0); chk1("t5_no_done2", d_done, 1'b0);
    cyc(); chk1("t5_regrant", mem_req, 1'b1); chk32("t5_addr", mem_addr, 32'h80);
    mem_ready = 1; mem_rdata = 32'h0000_0055;
    cyc(); mem_ready = 0;
    chk1("t5_done", d_done, 1'b1); chk32("t5_rdata", d_rdata, 32'h55);
    d_re = 0;
    cyc(); chk1("t5_done_off", d_done, 1'b0);

`ifdef ARB_STALL_CNT_EN
    // 6: three IF stall cycles, then five D stall cycles
    do_reset();
    cyc(); if_req = 1; if_addr = 32'h10;
    cyc();
    cyc(); mem_ready = 1;
    cyc(); mem_ready = 0; if_req = 0;
    cyc(); chk32("t6_if_cnt", if_stall_cnt, 32'd3);
    d_we = 1; d_addr = 32'h20; d_wdata = 32'h1; d_byte_slct = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      cyc(); mem_ready = (k == 4);
    end
    cyc(); mem_ready = 0; d_we = 0;
    cyc(); chk32("t6_d_cnt", d_stall_cnt, 32'd5); chk32("t6_if_cnt2", if_stall_cnt, 32'd3);
`endif

    // Randomized traffic against the transaction-level model
    idle_inputs();
    do_reset();
    m_phase = 0; m_own_d = 0; m_last_d = 0;
    i_was_done = 0; d_was_done = 0; acc_open = 0; wait_left = 0;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_we = 0; e_bsel = '0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      chk1("rnd_mem_req", mem_req, m_phase == 1);
      if (m_phase == 1) begin
        chk32("rnd_mem_addr", mem_addr, e_addr);
        chk1("rnd_mem_we", mem_we, e_we);
        chk32("rnd_mem_bsel", 32'(mem_byte_slct), 32'(e_bsel));
        if (e_we) chk32("rnd_mem_wdata", mem_wdata, e_wdata);
      end
      chk1("rnd_if_done", if_done, (m_phase == 2) && !m_own_d);
      chk1("rnd_d_done", d_done, (m_phase == 2) && m_own_d);
      if (m_phase == 2) begin
        if (m_own_d) chk32("rnd_d_rdata", d_rdata, e_rdata);
        else         chk32("rnd_if_rdata", if_rdata, e_rdata);
      end

      // Requesters hold until served, then drop or issue the next request
      if (i_was_done) begin
        if_req = 1'($urandom_range(1)); if_addr = $urandom;
      end else if (!if_req && ($urandom_range(2) == 0)) begin
        if_req = 1; if_addr = $urandom;
      end
      if (d_was_done || (!(d_re | d_we) && ($urandom_range(2) == 0))) begin
        kind = (d_was_done && ($urandom_range(1) == 0)) ? 3 : int'($urandom_range(2));
        d_re = (kind == 0) || (kind == 2);
        d_we = (kind == 1) || (kind == 2);
        d_addr = $urandom; d_wdata = $urandom; d_byte_slct = 4'($urandom);
      end
      i_was_done = (m_phase == 2) && !m_own_d;
      d_was_done = (m_phase == 2) && m_own_d;

      // Memory: 0-3 wait states per access
      mem_ready = 0; mem_rdata = $urandom;
      if (mem_req) begin
        if (!acc_open) begin acc_open = 1; wait_left = int'($urandom_range(3)); end
        if (wait_left == 0) begin mem_ready = 1; acc_open = 0; end
        else wait_left--;
      end

      #1;
      chk1("rnd_if_stall", if_stall, if_req && !((m_phase == 2) && !m_own_d));
      chk1("rnd_d_stall", d_stall, (d_re || d_we) && !((m_phase == 2) && m_own_d));

      if (m_phase == 0) begin
        if ((d_re || d_we) && !(m_last_d && if_req && !if_flush)) begin
          m_phase = 1; m_own_d = 1; m_last_d = 1;
          e_addr = d_addr; e_we = d_we; e_wdata = d_wdata;
          e_bsel = d_we ? d_byte_slct : 4'hF;
        end else if (if_req && !if_flush) begin
          m_phase = 1; m_own_d = 0; m_last_d = 0;
          e_addr = if_addr; e_we = 0; e_bsel = 4'hF;
        end
      end else if (m_phase == 1) begin
        if (mem_ready) begin m_phase = 2; e_rdata = mem_rdata; end
      end else begin
        m_phase = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
